// File: rtl/qos_rd_scheduler.sv
// Five-queue read drain scheduler: queue 4 strict priority, queues 0-3 weighted round robin; one word in flight.
// Latency: grant registered in IDLE, pop next cycle, word valid two edges after grant; backpressure holds OUT until iReady.
// Optional starvation guard for queues 0-3 under queue-4 load enabled by QOS_STARVE_GUARD_EN.
module qos_rd_scheduler #(
    parameter int DSIZE        = 32,
    parameter int W0           = 1,
    parameter int W1           = 2,
    parameter int W2           = 3,
    parameter int W3           = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic [4:0]           iEmpty,
    input  logic [5*DSIZE-1:0]   iRdData,
    output logic [4:0]           oRd,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [DSIZE-1:0]     oData,
    output logic [2:0]           oClass
);

    typedef enum logic [1:0] {IDLE, POP, CAP, OUT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       g_q, g_d;
    logic [DSIZE-1:0] data_q, data_d;
    logic [2:0]       class_q, class_d;
    logic             valid_q, valid_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       credit_q [4];
    logic [3:0]       credit_d [4];

    logic             lo_any;
    logic [3:0]       elig;
    logic             reload;
    logic [1:0]       wrr_g;
    logic [1:0]       idx;
    logic [3:0]       base;
    logic             starve;

    function automatic logic [3:0] weight(input logic [1:0] i);
        case (i)
            2'd0:    weight = 4'(W0);
            2'd1:    weight = 4'(W1);
            2'd2:    weight = 4'(W2);
            default: weight = 4'(W3);
        endcase
    endfunction

    // WRR winner: first eligible queue scanning upward from the pointer.
    // When nobody non-empty has credit left, the credits are treated as reloaded.
    always_comb begin
        lo_any = ~&iEmpty[3:0];
        for (int i = 0; i < 4; i++) begin
            elig[i] = ~iEmpty[i] & (credit_q[i] != 4'd0);
        end
        reload = lo_any & (elig == 4'd0);
        if (reload) begin
            elig = ~iEmpty[3:0];
        end
        wrr_g = ptr_q;
        idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (elig[idx]) begin
                wrr_g = idx;
            end
        end
        base = reload ? weight(wrr_g) : credit_q[wrr_g];
    end

`ifdef QOS_STARVE_GUARD_EN
    logic [7:0] cnt_q, cnt_d;
    assign starve = lo_any && (cnt_q == 8'(STARVE_LIMIT));
`else
    logic unused_starve_cfg;
    assign starve            = 1'b0;
    assign unused_starve_cfg = (STARVE_LIMIT > 0);
`endif

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        data_d   = data_q;
        class_d  = class_q;
        valid_d  = valid_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
`ifdef QOS_STARVE_GUARD_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (~&iEmpty) begin
                    state_d = POP;
                    if (!iEmpty[4] && !starve) begin
                        g_d = 3'd4;
`ifdef QOS_STARVE_GUARD_EN
                        cnt_d = lo_any ? cnt_q + 8'd1 : 8'd0;
`endif
                    end else begin
                        g_d = {1'b0, wrr_g};
                        if (reload) begin
                            for (int i = 0; i < 4; i++) begin
                                credit_d[i] = weight(2'(i));
                            end
                        end
                        credit_d[wrr_g] = base - 4'd1;
                        ptr_d = (base == 4'd1) ? wrr_g + 2'd1 : wrr_g;
`ifdef QOS_STARVE_GUARD_EN
                        cnt_d = 8'd0;
`endif
                    end
                end
            end
            POP: state_d = CAP;
            CAP: begin
                data_d  = iRdData[g_q*DSIZE +: DSIZE];
                class_d = g_q;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (iReady) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            g_q     <= '0;
            data_q  <= '0;
            class_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                credit_q[i] <= weight(2'(i));
            end
`ifdef QOS_STARVE_GUARD_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            data_q   <= data_d;
            class_q  <= class_d;
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
`ifdef QOS_STARVE_GUARD_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Pop is masked by reset so a reset landing mid-POP never drains a queue.
    always_comb begin
        oRd = '0;
        if (state_q == POP && !iReset) begin
            oRd[g_q] = 1'b1;
        end
    end

    assign oValid = valid_q;
    assign oData  = data_q;
    assign oClass = class_q;

endmodule

// File: tb/tb_qos_rd_scheduler.sv
// Bench for qos_rd_scheduler: queue environment, directed vector table, hand sequences, random run vs reference model.
module tb_qos_rd_scheduler;

    localparam int DW = 32;
    localparam int SL = 8;

    logic            iClk = 1'b0;
    logic            iReset;
    logic [4:0]      iEmpty;
    logic [5*DW-1:0] iRdData;
    logic [4:0]      oRd;
    logic            oValid;
    logic            iReady;
    logic [DW-1:0]   oData;
    logic [2:0]      oClass;

    qos_rd_scheduler #(
        .DSIZE(DW), .W0(1), .W1(2), .W2(3), .W3(4), .STARVE_LIMIT(SL)
    ) dut (
        .iClk(iClk), .iReset(iReset), .iEmpty(iEmpty), .iRdData(iRdData),
        .oRd(oRd), .oValid(oValid), .iReady(iReady), .oData(oData), .oClass(oClass)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int          cls;
        logic [31:0] dat;
    } item_t;

    typedef struct {
        logic [4:0][7:0]  cnt;
        int               nexp;
        logic [23:0][2:0] expc;
        logic [31:0]      d0;
    } vec_t;

    logic [31:0] fq [5][$];
    logic [31:0] rd_reg [5];
    item_t       exp_q [$];
    int          log_cls [$];
    logic [31:0] log_dat [$];

    int          wts [4] = '{1, 2, 3, 4};
    int          m_cred [4];
    int          m_ptr;
    int          m_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          npops = 0;
    int          rdy_mode = 0;
    bit          push_en = 0;
    bit          hold_v = 0;
    bit          acc_last = 0;
    logic [31:0] hold_d;
    logic [2:0]  hold_c;
    logic [4:0]  cur_empty;
    int          seq = 0;
    vec_t        vt [4];
    int          pat [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic logic [31:0] mkword(int q, int n);
        return 32'hA5A5_0000 | ((n & 255) << 8) | (q & 15);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cred[i] = wts[i];
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // Grant decision from the rules: strict queue 4, else credit-based round robin.
    task automatic model_grant(input logic [4:0] e, output int g);
        bit lo;
        bit starve;
        lo = (e[3:0] != 4'hF);
        starve = 0;
`ifdef QOS_STARVE_GUARD_EN
        starve = lo && (m_cnt == SL);
`endif
        if (!e[4] && !starve) begin
            g = 4;
            m_cnt = lo ? m_cnt + 1 : 0;
        end else begin
            g = -1;
            for (int pass = 0; pass < 2; pass++) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (g < 0 && !e[i] && m_cred[i] > 0) g = i;
                end
                if (g < 0) for (int i = 0; i < 4; i++) m_cred[i] = wts[i];
            end
            if (g >= 0) begin
                m_cred[g] = m_cred[g] - 1;
                m_ptr = (m_cred[g] == 0) ? (g + 1) % 4 : g;
            end
            m_cnt = 0;
        end
    endtask

    task automatic drive_ports();
        for (int i = 0; i < 5; i++) begin
            iEmpty[i] = (fq[i].size() == 0);
            iRdData[i*DW +: DW] = rd_reg[i];
        end
        cur_empty = iEmpty;
    endtask

    task automatic tick();
        int    gi;
        int    mg;
        int    j;
        item_t it;
        @(negedge iClk);
        if (iReset) begin
            chk("rst_rd", 32'(oRd), 0);
            chk("rst_vld", 32'(oValid), 0);
            chk("rst_dat", oData, 0);
            chk("rst_cls", 32'(oClass), 0);
            model_reset();
            exp_q.delete();
            hold_v = 0;
            acc_last = 0;
        end else begin
            if (acc_last) chk("vld_drop", 32'(oValid), 0);
            if (hold_v) begin
                chk("hold_vld", 32'(oValid), 1);
                chk("hold_dat", oData, hold_d);
                chk("hold_cls", 32'(oClass), 32'(hold_c));
                chk("hold_rd", 32'(oRd), 0);
            end
            if (oRd != 5'd0) begin
                gi = 0;
                for (int i = 0; i < 5; i++) if (oRd[i]) gi = i;
                chk("rd_onehot", $countones(oRd), 1);
                chk("rd_nonempty", 32'(cur_empty[gi]), 0);
                model_grant(cur_empty, mg);
                chk("grant", gi, mg);
                npops++;
                if (fq[gi].size() > 0) begin
                    rd_reg[gi] = fq[gi].pop_front();
                    it.cls = gi;
                    it.dat = rd_reg[gi];
                    exp_q.push_back(it);
                end
            end
        end
        if (push_en && $urandom_range(0, 4) == 0) begin
            j = ($urandom_range(0, 7) == 0) ? 4 : int'($urandom_range(0, 3));
            fq[j].push_back(mkword(j, seq));
            seq++;
        end
        case (rdy_mode)
            0:       iReady = 1'b1;
            1:       iReady = 1'b0;
            default: iReady = 1'($urandom_range(0, 1));
        endcase
        acc_last = 0;
        hold_v = 0;
        if (!iReset && oValid) begin
            if (iReady) begin
                chk("inflight", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk("out_cls", 32'(oClass), exp_q[0].cls);
                    chk("out_dat", oData, exp_q[0].dat);
                    void'(exp_q.pop_front());
                end
                log_cls.push_back(int'(oClass));
                log_dat.push_back(oData);
                acc_last = 1;
            end else begin
                hold_v = 1;
                hold_d = oData;
                hold_c = oClass;
            end
        end
        drive_ports();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (n < bound && !(iEmpty == 5'h1F && exp_q.size() == 0 && !oValid && oRd == 5'd0)) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(n < bound), 1);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int total;
        total = 0;
        iReset = 1'b1;
        rdy_mode = 0;
        for (int q = 0; q < 5; q++) begin
            fq[q].delete();
            for (int n = 0; n < int'(v.cnt[q]); n++) fq[q].push_back(mkword(q, n));
            total += int'(v.cnt[q]);
        end
        drive_ports();
        tick();
        tick();
        iReset = 1'b0;
        log_cls.delete();
        log_dat.delete();
        npops = 0;
        drain(3000);
        chk($sformatf("v%0d_pops", id), npops, total);
        chk($sformatf("v%0d_words", id), log_cls.size(), total);
        for (int k = 0; k < v.nexp; k++) begin
            if (k < log_cls.size()) chk($sformatf("v%0d_cls%0d", id, k), log_cls[k], 32'(v.expc[k]));
        end
        if (log_dat.size() > 0) chk($sformatf("v%0d_d0", id), log_dat[0], v.d0);
    endtask

    initial begin
        int n;

        for (int i = 0; i < 4; i++) begin
            vt[i].cnt  = '0;
            vt[i].expc = '0;
            vt[i].nexp = 0;
        end
        vt[0].cnt[2] = 8'd1;  vt[0].nexp = 1;  vt[0].expc[0] = 3'd2;  vt[0].d0 = 32'hA5A5_0002;
        vt[1].cnt[0] = 8'd3;  vt[1].cnt[4] = 8'd3;  vt[1].nexp = 6;  vt[1].d0 = 32'hA5A5_0004;
        for (int k = 0; k < 6; k++) vt[1].expc[k] = (k < 3) ? 3'd4 : 3'd0;
        for (int q = 0; q < 4; q++) vt[2].cnt[q] = 8'd20;
        vt[2].nexp = 20;  vt[2].d0 = 32'hA5A5_0000;
        for (int k = 0; k < 20; k++) vt[2].expc[k] = 3'(pat[k % 10]);
        vt[3].cnt[4] = 8'd20;  vt[3].cnt[1] = 8'd2;  vt[3].nexp = 22;  vt[3].d0 = 32'hA5A5_0004;
        for (int k = 0; k < 22; k++) begin
`ifdef QOS_STARVE_GUARD_EN
            vt[3].expc[k] = (k == 8 || k == 17) ? 3'd1 : 3'd4;
`else
            vt[3].expc[k] = (k < 20) ? 3'd4 : 3'd1;
`endif
        end

        for (int i = 0; i < 5; i++) rd_reg[i] = '0;
        model_reset();
        iReset = 1'b1;
        iReady = 1'b1;

        // Reset with every queue non-empty, then first pop timing.
        for (int q = 0; q < 5; q++) fq[q].push_back(mkword(q, 0));
        drive_ports();
        tick();
        tick();
        iReset = 1'b0;
        log_cls.delete();
        log_dat.delete();
        tick();
        chk("first_pop", 32'(oRd), 32'h10);
        tick();
        chk("pop_one_cycle", 32'(oRd), 0);
        drain(200);
        chk("rst_seq_words", log_cls.size(), 5);

        for (int v = 0; v < 4; v++) run_vec(vt[v], v);

        // Backpressure: word held 10 cycles, then one accept cycle.
        iReset = 1'b0;
        fq[3].push_back(mkword(3, 7));
        rdy_mode = 1;
        drive_ports();
        n = 0;
        while (!oValid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_reach", 32'(oValid), 1);
        repeat (10) begin
            tick();
            chk("bp_rd", 32'(oRd), 0);
        end
        chk("bp_dat", oData, 32'hA5A5_0703);
        chk("bp_cls", 32'(oClass), 3);
        rdy_mode = 0;
        tick();
        rdy_mode = 1;
        tick();
        chk("bp_drop", 32'(oValid), 0);

        // Reset while a word waits in OUT: word dropped, nothing replayed.
        fq[0].push_back(mkword(0, 9));
        drive_ports();
        n = 0;
        while (!oValid && n < 20) begin
            tick();
            n++;
        end
        chk("mid_reach", 32'(oValid), 1);
        npops = 0;
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        repeat (4) tick();
        chk("mid_no_vld", 32'(oValid), 0);
        chk("mid_no_pop", npops, 0);

        // Random traffic and ready against the reference model.
        rdy_mode = 2;
        push_en = 1;
        repeat (2000) tick();
        push_en = 0;
        drain(6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
